router_output_arbiter: RTL and testbench
========================================

ROUTER_OUTPUT_ARBITER -- requirements
Module: router_output_arbiter

Interface
REQ-001 SHALL have parameter REN, default 5, number of router ports (core, up, down, right, left).
REQ-002 SHALL have parameter PL, default `PL from noc.svh, packet width in bits.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum cycles in SEND awaiting written.
REQ-004 SHALL have port clk  input  1  sole clock, all state on posedge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req_valid  input  REN  input buffer i holds a packet routed to this output.
REQ-007 SHALL have port req_data  input  REN x PL  packet held by input buffer i.
REQ-008 SHALL have port out_ready  input  1  downstream buffer can accept a packet.
REQ-009 SHALL have port written  input  1  one-cycle pulse, downstream stored out_data.
REQ-010 SHALL have port out_valid  output  1  out_data is a packet offered downstream.
REQ-011 SHALL have port out_data  output  PL  registered copy of granted packet.
REQ-012 SHALL have port grant  output  REN  one-hot current owner, zero when none.
REQ-013 SHALL have port purge  output  REN  one-cycle pulse telling input i its packet is consumed.
REQ-014 SHALL have port timeout  output  1  one-cycle pulse on abandoned transfer.

Function
REQ-015 SHALL implement FSM states IDLE, SEND, RELEASE.
REQ-016 IDLE: when out_ready=1 and req_valid!=0, SHALL grant first requester at index >= ptr (wrapping past REN-1 to 0), latch its req_data into out_data, set grant, enter SEND on the same edge.
REQ-017 IDLE with out_ready=0 or req_valid=0 SHALL stay IDLE with grant=0, out_valid=0.
REQ-018 SEND SHALL hold out_valid=1 and out_data/grant stable; out_valid rises the edge after the arbitration decision (1-cycle latency).
REQ-019 SEND with written=1 SHALL go to RELEASE, set ptr=(g+1) mod REN, drop out_valid.
REQ-020 RELEASE SHALL assert purge[g] for exactly one cycle, clear grant, return to IDLE.
REQ-021 SEND SHALL count cycles; after TIMEOUT cycles without written it SHALL return to IDLE, pulse timeout, advance ptr to (g+1) mod REN, assert no purge.
REQ-022 written on the expiry cycle SHALL win: normal RELEASE, no timeout pulse.
REQ-023 written in IDLE or RELEASE SHALL be ignored.
REQ-024 req_valid or req_data changes of the granted input during SEND SHALL be ignored (packet already latched).
REQ-025 Minimum per-packet occupancy SHALL be 3 cycles (IDLE, SEND, RELEASE); back-to-back grant from RELEASE is not permitted.
REQ-026 ptr SHALL be $clog2(REN) bits, wrap REN-1 -> 0; counter SHALL be $clog2(TIMEOUT+1) bits, saturating, cleared on SEND entry.
REQ-027 grant, purge SHALL each be one-hot or zero at all times.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, ptr=0, counter=0, out_valid=0, out_data=0, grant=0, purge=0, timeout=0.
REQ-029 Reset mid-SEND SHALL abandon the packet with no purge; requester keeps req_valid and is rearbitrated after release.

Structure
REQ-030 REN, PL SHALL come from shared noc.svh; FSM state typedef SHALL live in the shared NoC package.
REQ-031 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs req, ptr; outputs one-hot grant, index, any).

Verification
REQ-032 Single req_valid=00100, out_ready=1, written on 2nd SEND cycle -> grant=00100, out_valid 1 cycle after req, purge=00100 one cycle, ptr=3.
REQ-033 req_valid=11111 held, written each SEND cycle -> grant sequence 0,1,2,3,4,0 (indices), ptr wraps 4->0.
REQ-034 req_valid=10001, ptr=1 -> grant index 4, then index 0.
REQ-035 Never assert written, TIMEOUT=16 -> out_valid high 16 cycles, timeout pulse, purge never asserted, next grant to next requester.
REQ-036 out_ready=0 with requests -> stays IDLE, out_valid=0; out_ready=1 -> grant next cycle.
REQ-037 rst_n low mid-SEND -> all outputs 0 asynchronously; after release, same requester regranted.

Source files
------------

// File: rtl/router_output_arbiter_pkg.sv
// Shared NoC constants and the output-arbiter FSM state type.
// Imported by the arbiter, its round-robin picker and the bench.
package router_output_arbiter_pkg;

  localparam int NOC_REN = 5;   // core, up, down, right, left
  localparam int NOC_PL  = 32;  // packet width in bits

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SEND    = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/router_output_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr,
// wrapping past REN-1 back to 0.
module rr_pick #(
  parameter int REN = 5,
  parameter int PW  = (REN > 1) ? $clog2(REN) : 1
) (
  input  logic [REN-1:0] req,
  input  logic [PW-1:0]  ptr,
  output logic [REN-1:0] onehot,
  output logic [PW-1:0]  idx,
  output logic           any
);

  always_comb begin
    int j;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    // Walk from the farthest offset down so the nearest requester wins last.
    for (int k = REN - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= REN) j = j - REN;
      if (req[j]) begin
        onehot    = '0;
        onehot[j] = 1'b1;
        idx       = PW'(j);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_output_arbiter.sv
// Router output-port arbiter: round-robin grant, one packet in flight,
// purge on downstream write, timeout on abandoned transfers.
module router_output_arbiter
  import router_output_arbiter_pkg::*;
#(
  parameter int REN     = NOC_REN,
  parameter int PL      = NOC_PL,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [REN-1:0]          req_valid,
  input  logic [REN-1:0][PL-1:0]  req_data,
  input  logic                    out_ready,
  input  logic                    written,
  output logic                    out_valid,
  output logic [PL-1:0]           out_data,
  output logic [REN-1:0]          grant,
  output logic [REN-1:0]          purge,
  output logic                    timeout,
  output arb_state_e              dbg_state
);

  localparam int PW = (REN > 1) ? $clog2(REN) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  // Handshake: out_valid stays high with stable out_data until the
  // downstream pulses written; the owning input is then purged once.

  arb_state_e      state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gidx;
  logic [CW-1:0]   cnt;
  logic [REN-1:0]  pick_onehot;
  logic [PW-1:0]   pick_idx;
  logic            pick_any;
  logic [PW-1:0]   next_ptr;

  rr_pick #(.REN(REN), .PW(PW)) u_pick (
    .req    (req_valid),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign next_ptr  = (gidx == PW'(REN - 1)) ? '0 : gidx + PW'(1);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      ptr       <= '0;
      gidx      <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      grant     <= '0;
      purge     <= '0;
      timeout   <= 1'b0;
    end else begin
      purge   <= '0;
      timeout <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (out_ready && pick_any) begin
            grant     <= pick_onehot;
            gidx      <= pick_idx;
            out_data  <= req_data[pick_idx];
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= ARB_SEND;
          end else begin
            grant     <= '0;
            out_valid <= 1'b0;
          end
        end
        ARB_SEND: begin
          // written on the expiry cycle takes priority over the timeout.
          if (written) begin
            out_valid <= 1'b0;
            purge     <= grant;
            ptr       <= next_ptr;
            state     <= ARB_RELEASE;
          end else if (cnt >= CW'(TIMEOUT - 1)) begin
            out_valid <= 1'b0;
            grant     <= '0;
            timeout   <= 1'b1;
            ptr       <= next_ptr;
            state     <= ARB_IDLE;
          end else if (cnt != CW'(TIMEOUT)) begin
            cnt <= cnt + CW'(1);
          end
        end
        ARB_RELEASE: begin
          grant <= '0;
          state <= ARB_IDLE;
        end
        default: begin
          state     <= ARB_IDLE;
          grant     <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_router_output_arbiter.sv
// Self-checking bench for router_output_arbiter: directed scenarios plus
// randomized traffic compared against a transaction-level reference model.
module tb_router_output_arbiter;
  import router_output_arbiter_pkg::*;

  localparam int REN     = 5;
  localparam int PL      = 32;
  localparam int TIMEOUT = 16;

  logic                   clk;
  logic                   rst_n;
  logic [REN-1:0]         req_valid;
  logic [REN-1:0][PL-1:0] req_data;
  logic                   out_ready;
  logic                   written;
  logic                   out_valid;
  logic [PL-1:0]          out_data;
  logic [REN-1:0]         grant;
  logic [REN-1:0]         purge;
  logic                   timeout;
  arb_state_e             dbg_state;

  int n_tests;
  int n_fail;

  router_output_arbiter #(.REN(REN), .PL(PL), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .out_ready (out_ready),
    .written   (written),
    .out_valid (out_valid),
    .out_data  (out_data),
    .grant     (grant),
    .purge     (purge),
    .timeout   (timeout),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Tracks the packet in flight as (phase, owner, cycles spent sending).
  arb_state_e     m_phase;
  int             m_ptr;
  int             m_owner;
  int             m_elapsed;
  logic           m_valid;
  logic [PL-1:0]  m_data;
  logic           m_timeout;
  logic           m_purging;

  function automatic logic [REN-1:0] bit_of(int i);
    logic [REN-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_phase   = ARB_IDLE;
    m_ptr     = 0;
    m_owner   = -1;
    m_elapsed = 0;
    m_valid   = 1'b0;
    m_data    = '0;
    m_timeout = 1'b0;
    m_purging = 1'b0;
  endtask

  task automatic model_edge();
    int pick;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_timeout = 1'b0;
    m_purging = 1'b0;
    case (m_phase)
      ARB_IDLE: begin
        pick = -1;
        if (out_ready)
          for (int k = 0; k < REN; k++)
            if (pick < 0 && req_valid[(m_ptr + k) % REN]) pick = (m_ptr + k) % REN;
        if (pick >= 0) begin
          m_owner   = pick;
          m_data    = req_data[pick];
          m_valid   = 1'b1;
          m_elapsed = 0;
          m_phase   = ARB_SEND;
        end else begin
          m_owner = -1;
          m_valid = 1'b0;
        end
      end
      ARB_SEND: begin
        if (written) begin
          m_valid   = 1'b0;
          m_purging = 1'b1;
          m_ptr     = (m_owner + 1) % REN;
          m_phase   = ARB_RELEASE;
        end else begin
          m_elapsed++;
          if (m_elapsed == TIMEOUT) begin
            m_valid   = 1'b0;
            m_timeout = 1'b1;
            m_ptr     = (m_owner + 1) % REN;
            m_owner   = -1;
            m_phase   = ARB_IDLE;
          end
        end
      end
      default: begin
        m_owner = -1;
        m_phase = ARB_IDLE;
      end
    endcase
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [REN-1:0] eg;
    eg = (m_owner >= 0) ? bit_of(m_owner) : '0;
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("grant", 64'(grant), 64'(eg));
    check("purge", 64'(purge), 64'(m_purging ? eg : '0));
    check("timeout", 64'(timeout), 64'(m_timeout));
    check("state", 64'(dbg_state), 64'(m_phase));
    if (m_valid) check("out_data", 64'(out_data), 64'(m_data));
  endtask

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic randomize_data();
    for (int i = 0; i < REN; i++) req_data[i] = $urandom();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("reset_data", 64'(out_data), 64'(0));
    step();
    step();
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int vcount;
    bit  saw_to;
    bit  saw_purge;
    int  stall;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    out_ready = 1'b0;
    written   = 1'b0;
    randomize_data();
    model_reset();

    // Single requester, written on the second SEND cycle, ptr lands on 3.
    do_reset();
    req_valid = 5'b00100;
    out_ready = 1'b1;
    step();
    check("single_grant", 64'(grant), 64'(5'b00100));
    check("single_valid", 64'(out_valid), 64'(1));
    step();
    written = 1'b1;
    step();
    written = 1'b0;
    check("single_purge", 64'(purge), 64'(5'b00100));
    req_valid = 5'b01100;
    step();
    check("single_purge_end", 64'(purge), 64'(0));
    step();
    check("ptr_after_2", 64'(grant), 64'(5'b01000));

    // All ports requesting: indices 0,1,2,3,4,0.
    do_reset();
    req_valid = 5'b11111;
    for (int n = 0; n < 6; n++) begin
      randomize_data();
      step();
      check("rr_all", 64'(grant), 64'(bit_of(n % REN)));
      written = 1'b1;
      step();
      written = 1'b0;
      step();
    end

    // ptr=1 with requests on 0 and 4: index 4 then index 0.
    do_reset();
    req_valid = 5'b00001;
    step();
    written = 1'b1;
    step();
    written = 1'b0;
    req_valid = 5'b10001;
    step();
    step();
    check("wrap_first", 64'(grant), 64'(5'b10000));
    written = 1'b1;
    step();
    written = 1'b0;
    step();
    step();
    check("wrap_second", 64'(grant), 64'(5'b00001));

    // Timeout: written never arrives.
    do_reset();
    req_valid = 5'b00011;
    vcount = 0;
    saw_to = 1'b0;
    saw_purge = 1'b0;
    for (int c = 0; c < TIMEOUT + 4 && !saw_to; c++) begin
      step();
      if (out_valid) vcount++;
      if (timeout) saw_to = 1'b1;
      if (purge != 0) saw_purge = 1'b1;
    end
    check("to_seen", 64'(saw_to), 64'(1));
    check("to_valid_cycles", 64'(vcount), 64'(TIMEOUT));
    check("to_no_purge", 64'(saw_purge), 64'(0));
    step();
    check("to_next_grant", 64'(grant), 64'(5'b00010));

    // Written on the expiry cycle wins over timeout.
    do_reset();
    req_valid = 5'b00001;
    step();
    for (int c = 0; c < TIMEOUT - 1; c++) step();
    written = 1'b1;
    step();
    written = 1'b0;
    check("expiry_purge", 64'(purge), 64'(5'b00001));
    check("expiry_no_to", 64'(timeout), 64'(0));

    // Downstream not ready: hold in IDLE.
    do_reset();
    out_ready = 1'b0;
    req_valid = 5'b01010;
    written   = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("not_ready_valid", 64'(out_valid), 64'(0));
    end
    written   = 1'b0;
    out_ready = 1'b1;
    step();
    check("ready_grant", 64'(grant), 64'(5'b00010));

    // Asynchronous reset in the middle of SEND.
    do_reset();
    req_valid = 5'b00100;
    step();
    step();
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_valid", 64'(out_valid), 64'(0));
    check("async_grant", 64'(grant), 64'(0));
    check("async_purge", 64'(purge), 64'(0));
    check("async_data", 64'(out_data), 64'(0));
    step();
    rst_n = 1'b1;
    step();
    check("regrant", 64'(grant), 64'(5'b00100));

    // Randomized traffic, with stall windows that force timeouts.
    do_reset();
    stall = 0;
    for (int c = 0; c < 1500; c++) begin
      req_valid = REN'($urandom_range(0, (1 << REN) - 1));
      randomize_data();
      out_ready = ($urandom_range(0, 3) != 0);
      if (stall == 0 && $urandom_range(0, 99) == 0) stall = $urandom_range(10, 40);
      if (stall > 0) begin
        stall--;
        written = 1'b0;
      end else begin
        written = ($urandom_range(0, 2) == 0);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
